multi_rate_divider: RTL and testbench
=====================================

# multi_rate_divider

Parametrised multi-channel clock divider. It generates NUM_CH independent, enable-gated tick pulses and 50 %-duty square waves from the single system clock. It supersedes the fixed one-hertz divider, and the traffic-light sequencer and display blocks use it for their slow timebases. Divide ratios are reprogrammable at run time through a valid/ready port, and a new ratio takes effect glitch-free at the next period boundary.

## Interface
- NUM_CH, 3: number of independent channels (1..8).
- CNT_W, 24: width of divide ratios and counters.
- DEFAULT_DIV, 100000: divide ratio loaded into every channel at reset (1 Hz from the 100 kHz system clock).
- clk  in  1  system clock; all logic on its rising edge.
- Sync_Reset  in  1  reset, asynchronous, active-high.
- en  in  NUM_CH  per-channel enable, sampled each edge.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  block can accept a configuration.
- cfg_ch  in  CH_W  target channel; CH_W = max(1, clog2(NUM_CH)).
- cfg_div  in  CNT_W  new divide ratio.
- tick  out  NUM_CH  one-cycle pulse per divide period.
- sq  out  NUM_CH  square wave, period 2*div cycles.

## Operation
- Per-channel state: cnt[CNT_W], div[CNT_W], sq flop, tick flop.
- Shared state: one pending slot (pend_div, pend_ch, pend_full).
- Reset values: cnt=0, div=DEFAULT_DIV, tick=0, sq=0, pend_full=0, cfg_ready=1. Pending data is discarded.
- Channel enabled (en[i]=1 at edge):
  - If cnt==div-1: cnt<=0, tick<=1, sq<=~sq (wrap edge).
  - Otherwise: cnt<=cnt+1, tick<=0.
- Channel disabled: cnt<=0, tick<=0, sq<=0. div is retained.
- Enable rising: counting restarts from 0. No partial period is carried over.
- Config handshake:
  - Transfer occurs when cfg_valid & cfg_ready at an edge. cfg_ch/cfg_div are captured into the pending slot and pend_full<=1.
  - cfg_ready = ~pend_full. There is one outstanding request at a time.
  - cfg_valid may stay high. The requester holds cfg_ch/cfg_div stable until the transfer.
- Apply rules:
  - The pending value applies to channel pend_ch at that channel's next wrap edge: div<=pend_div, cnt<=0, pend_full<=0.
  - If pend_ch is disabled at an edge, it applies on that edge instead.
  - The accept edge never also applies. Apply occurs on a later edge, even if the channel wraps on the accept edge.
- cfg_div = 0 is stored as 1.
- cfg_ch >= NUM_CH: the request is accepted and discarded. pend_full stays 0, so cfg_ready stays 1.
- div = 1: tick held high continuously while enabled; sq toggles every cycle.
- No arithmetic overflow: cnt never exceeds div-1, and div-1 is computed in CNT_W bits with div >= 1.

## Timing
- All outputs are registered. Nothing is combinational from inputs except that none exist; cfg_ready is a flop-derived output.
- en[i] first sampled high at edge E0 with div=D held: tick[i] is high during the cycle after edge E0+D-1, then every D cycles. Width is exactly 1 cycle for D >= 2.
- sq[i] toggles at each tick-setting edge: high D cycles, low D cycles.
- Config latency:
  - cfg_ready falls the cycle after the accept edge.
  - cfg_ready returns high the cycle after the apply edge.
  - Worst case accept-to-apply is old div + 1 cycles.
- The old ratio completes its current period. The first period at the new ratio starts at the apply edge. No shortened or doubled tick is produced.
- Sync_Reset asserted mid-period: all outputs go to reset values immediately (asynchronous). Counting resumes from 0 at the first edge after deassertion.
- Simultaneous en falling and wrap on the same edge: disable wins. No tick, cnt<=0, sq<=0, and a pending update for that channel applies.

## Test plan
- Reset and default: DEFAULT_DIV=10, en=3'b111 after reset. tick[0..2] pulse every 10 cycles, first 10 edges after enable. sq period 20 cycles. All outputs 0 during reset.
- Run-time change: ch1 at div 10. Send cfg_ch=1, cfg_div=4 at cnt=3. ch1 ticks once more at the old 10 boundary, then every 4 cycles. cfg_ready is low from accept until the cycle after that boundary. ch0 and ch2 are unaffected.
- Back-pressure: hold cfg_valid with two successive requests (ch0 div 5, then ch2 div 7). The second request transfers only after ch0 applies. Both ratios are verified by tick spacing.
- Edge values:
  - cfg_div=0 and cfg_div=1 give tick constantly high and sq toggling every cycle.
  - cfg_ch=3 with NUM_CH=3 leaves all divs unchanged and cfg_ready stays 1.
- Disable: drop en[2] mid-period with a pending update for ch2. tick[2]=0 and sq[2]=0 next cycle, and the update applies on that edge. Re-enable and the first tick arrives after the new div cycles.
- Async reset mid-operation: pulse Sync_Reset between clock edges for 150 us while pend_full=1. Outputs clear without a clock edge, cfg_ready=1, div returns to DEFAULT_DIV, and the pending update is lost.

Source files
------------

// File: rtl/multi_rate_divider.sv
// multi_rate_divider: NUM_CH independent enable-gated tick / square-wave
// generators sharing one system clock. Divide ratios are reprogrammed through
// a single-slot valid/ready port. A new ratio is applied only at the target
// channel's period boundary, or at once if that channel is disabled.
module multi_rate_divider #(
  parameter int          NUM_CH      = 3,
  parameter int          CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 32'd100000,
  localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              Sync_Reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  // A ratio of zero would make div-1 wrap around; treat it as divide-by-one.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    logic [CNT_W-1:0] r;
    if (d == '0) begin
      r = ONE;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Per-channel state
  logic [CNT_W-1:0]  cnt_r      [NUM_CH];
  logic [CNT_W-1:0]  div_r      [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt_s  [NUM_CH];
  logic [CNT_W-1:0]  div_nxt_s  [NUM_CH];
  logic [NUM_CH-1:0] tick_r;
  logic [NUM_CH-1:0] sq_r;
  logic [NUM_CH-1:0] tick_nxt_s;
  logic [NUM_CH-1:0] sq_nxt_s;
  logic [NUM_CH-1:0] wrap_s;
  logic [NUM_CH-1:0] apply_s;

  // Shared pending-configuration slot
  logic [CNT_W-1:0]  pend_div_r;
  logic [CH_W-1:0]   pend_ch_r;
  logic              pend_full_r;
  logic              pend_full_nxt_s;
  logic              cfg_ready_r;
  logic              accept_s;
  logic              ch_ok_s;
  logic              apply_any_s;

  assign tick      = tick_r;
  assign sq        = sq_r;
  assign cfg_ready = cfg_ready_r;

  // Channel next-state: count, wrap, disable and pending-ratio apply.
  // The slot flag is the registered one, so an accept edge cannot also apply.
  always_comb begin
    wrap_s  = '0;
    apply_s = '0;
    tick_nxt_s = '0;
    sq_nxt_s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt_s[i] = '0;
      div_nxt_s[i] = div_r[i];
      wrap_s[i]  = (cnt_r[i] == (div_r[i] - ONE));
      apply_s[i] = pend_full_r && (pend_ch_r == CH_W'(i)) && (!en[i] || wrap_s[i]);
      if (!en[i]) begin
        cnt_nxt_s[i]  = '0;
        tick_nxt_s[i] = 1'b0;
        sq_nxt_s[i]   = 1'b0;
      end else if (wrap_s[i]) begin
        cnt_nxt_s[i]  = '0;
        tick_nxt_s[i] = 1'b1;
        sq_nxt_s[i]   = ~sq_r[i];
      end else begin
        cnt_nxt_s[i]  = cnt_r[i] + ONE;
        tick_nxt_s[i] = 1'b0;
        sq_nxt_s[i]   = sq_r[i];
      end
      if (apply_s[i]) begin
        div_nxt_s[i] = pend_div_r;
      end else begin
        div_nxt_s[i] = div_r[i];
      end
    end
    apply_any_s = |apply_s;
  end

  // Handshake: accept into the empty slot; requests to absent channels are
  // consumed but never occupy the slot.
  always_comb begin
    accept_s        = cfg_valid && !pend_full_r;
    ch_ok_s         = (32'(cfg_ch) < 32'(NUM_CH));
    pend_full_nxt_s = pend_full_r;
    if (accept_s) begin
      pend_full_nxt_s = ch_ok_s;
    end else if (apply_any_s) begin
      pend_full_nxt_s = 1'b0;
    end else begin
      pend_full_nxt_s = pend_full_r;
    end
  end

  // Channel counters, ratios and registered outputs.
  always_ff @(posedge clk or posedge Sync_Reset) begin
    if (Sync_Reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= '0;
        div_r[i] <= DIV_RST;
      end
      tick_r <= '0;
      sq_r   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
        div_r[i] <= div_nxt_s[i];
      end
      tick_r <= tick_nxt_s;
      sq_r   <= sq_nxt_s;
    end
  end

  // Pending slot and the registered ready flag (always the inverse of the slot).
  always_ff @(posedge clk or posedge Sync_Reset) begin
    if (Sync_Reset) begin
      pend_div_r  <= ONE;
      pend_ch_r   <= '0;
      pend_full_r <= 1'b0;
      cfg_ready_r <= 1'b1;
    end else begin
      if (accept_s) begin
        pend_div_r <= clamp_div(cfg_div);
        pend_ch_r  <= cfg_ch;
      end else begin
        pend_div_r <= pend_div_r;
        pend_ch_r  <= pend_ch_r;
      end
      pend_full_r <= pend_full_nxt_s;
      cfg_ready_r <= ~pend_full_nxt_s;
    end
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed self-checking bench for multi_rate_divider (3 channels, default
// divide-by-10). Inputs are driven and outputs sampled 1 time unit after the
// rising edge; "edge k" in comments counts edges from the first enabled edge.
`timescale 1us/1ns
module tb_multi_rate_divider;

  logic       clk;
  logic       Sync_Reset;
  logic [2:0] en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [2:0] tick;
  logic [2:0] sq;

  int n_checks;
  int n_pass;

  multi_rate_divider #(
    .NUM_CH(3),
    .CNT_W(8),
    .DEFAULT_DIV(32'd10)
  ) dut (
    .clk(clk),
    .Sync_Reset(Sync_Reset),
    .en(en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .tick(tick),
    .sq(sq)
  );

  // 10 us period: 100 kHz system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    Sync_Reset = 1'b1;
    en         = 3'b000;
    cfg_valid  = 1'b0;
    cfg_ch     = 2'd0;
    cfg_div    = 8'd0;
    step();
    step();
    Sync_Reset = 1'b0;
  endtask

  task automatic send_cfg(input logic [1:0] ch, input logic [7:0] dv);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = dv;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    Sync_Reset = 1'b1;
    en         = 3'b000;
    cfg_valid  = 1'b0;
    cfg_ch     = 2'd0;
    cfg_div    = 8'd0;

    // ---- 1: reset values and default divide-by-10 on all channels
    #2;
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_sq", 32'(sq), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    step();
    step();
    Sync_Reset = 1'b0;
    en = 3'b111;
    for (int k = 0; k < 30; k++) begin
      step();
      check("def_tick", 32'(tick), (((k + 1) % 10) == 0) ? 32'd7 : 32'd0);
      check("def_sq", 32'(sq), ((((k + 1) / 10) % 2) == 1) ? 32'd7 : 32'd0);
    end

    // ---- 2: run-time change of ch1 to 4 while cnt=3
    for (int k = 0; k < 3; k++) step();      // edges 30..32, cnt=3
    send_cfg(2'd1, 8'd4);
    step();                                  // edge 33: accept
    cfg_valid = 1'b0;
    check("chg_ready_acc", 32'(cfg_ready), 32'd0);
    for (int j = 0; j < 5; j++) begin        // edges 34..38
      step();
      check("chg_ready_wait", 32'(cfg_ready), 32'd0);
      check("chg_tick_wait", 32'(tick), 32'd0);
    end
    step();                                  // edge 39: old boundary + apply
    check("chg_tick_bnd", 32'(tick), 32'd7);
    check("chg_ready_apply", 32'(cfg_ready), 32'd1);
    for (int m = 1; m <= 10; m++) begin
      step();
      check("chg_tick", 32'(tick),
            32'({(m == 10) ? 1'b1 : 1'b0, ((m % 4) == 0) ? 1'b1 : 1'b0, (m == 10) ? 1'b1 : 1'b0}));
      check("chg_sq", 32'(sq),
            32'({(m >= 10) ? 1'b1 : 1'b0, (((m / 4) % 2) == 1) ? 1'b1 : 1'b0, (m >= 10) ? 1'b1 : 1'b0}));
    end

    // ---- 3: back-pressure, ch0->5 then ch2->7 with cfg_valid held
    reset_dut();
    en = 3'b111;
    send_cfg(2'd0, 8'd5);
    for (int k = 0; k < 36; k++) begin
      step();
      if (k == 0) begin
        cfg_ch  = 2'd2;
        cfg_div = 8'd7;
      end else if (k == 10) begin
        cfg_valid = 1'b0;
      end else begin
        cfg_valid = cfg_valid;
      end
      check("bp_tick0", 32'(tick[0]), ((k == 9) || (k > 9 && ((k - 9) % 5) == 0)) ? 32'd1 : 32'd0);
      check("bp_tick1", 32'(tick[1]), (((k + 1) % 10) == 0) ? 32'd1 : 32'd0);
      check("bp_tick2", 32'(tick[2]), ((k == 9) || (k == 19) || (k > 19 && ((k - 19) % 7) == 0)) ? 32'd1 : 32'd0);
      check("bp_ready", 32'(cfg_ready), ((k == 9) || (k >= 19)) ? 32'd1 : 32'd0);
    end

    // ---- 4: edge values, div 0 and 1, out-of-range channel
    reset_dut();
    send_cfg(2'd0, 8'd0);
    step();                                  // accept
    cfg_valid = 1'b0;
    check("ev_ready_acc0", 32'(cfg_ready), 32'd0);
    step();                                  // ch0 disabled: applies
    check("ev_ready_app0", 32'(cfg_ready), 32'd1);
    send_cfg(2'd1, 8'd1);
    step();
    cfg_valid = 1'b0;
    step();
    check("ev_ready_app1", 32'(cfg_ready), 32'd1);
    en = 3'b011;
    for (int k = 0; k < 4; k++) begin
      step();
      check("ev_tick_const", 32'(tick), 32'd3);
      check("ev_sq_toggle", 32'(sq), ((k % 2) == 0) ? 32'd3 : 32'd0);
    end
    send_cfg(2'd3, 8'd2);
    step();
    cfg_valid = 1'b0;
    check("ev_ready_badch", 32'(cfg_ready), 32'd1);
    step();
    check("ev_ready_badch2", 32'(cfg_ready), 32'd1);
    check("ev_tick_badch", 32'(tick), 32'd3);
    en = 3'b111;
    for (int k = 0; k < 10; k++) begin
      step();
      check("ev_tick_ch2def", 32'(tick), (k == 9) ? 32'd7 : 32'd3);
    end

    // ---- 5: disable ch2 mid-period with a pending update for it
    reset_dut();
    en = 3'b111;
    for (int k = 0; k < 10; k++) step();     // edges 0..9, sq=111
    check("dis_sq_pre", 32'(sq), 32'd7);
    send_cfg(2'd2, 8'd6);
    step();                                  // edge 10: accept
    cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();      // edges 11..13
    check("dis_ready_pend", 32'(cfg_ready), 32'd0);
    en = 3'b011;
    step();                                  // edge 14: disable + apply
    check("dis_tick", 32'(tick), 32'd0);
    check("dis_sq", 32'(sq), 32'd3);
    check("dis_ready", 32'(cfg_ready), 32'd1);
    step();
    en = 3'b111;
    for (int k = 0; k < 13; k++) begin
      step();
      check("dis_reen_tick2", 32'(tick[2]), ((k == 5) || (k == 11)) ? 32'd1 : 32'd0);
      check("dis_reen_sq2", 32'(sq[2]), ((k >= 5) && (k < 11)) ? 32'd1 : 32'd0);
    end

    // ---- 6: asynchronous reset between edges with a pending update
    reset_dut();
    en = 3'b111;
    for (int k = 0; k < 10; k++) step();
    send_cfg(2'd1, 8'd3);
    step();                                  // accept
    cfg_valid = 1'b0;
    step();
    check("ar_pre_ready", 32'(cfg_ready), 32'd0);
    check("ar_pre_sq", 32'(sq), 32'd7);
    #3;
    Sync_Reset = 1'b1;
    #1;                                      // no clock edge since assertion
    check("ar_tick", 32'(tick), 32'd0);
    check("ar_sq", 32'(sq), 32'd0);
    check("ar_ready", 32'(cfg_ready), 32'd1);
    #150;
    Sync_Reset = 1'b0;
    for (int k = 0; k < 13; k++) begin
      step();
      check("ar_post_tick", 32'(tick), (k == 9) ? 32'd7 : 32'd0);
      check("ar_post_ready", 32'(cfg_ready), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
